// File: rtl/itype_ctrl_pkg.sv
// Shared constants for the I-type sequencing controller: opcodes, ALU functions
// and the 3-bit FSM state encoding.
package itype_ctrl_pkg;

    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_DECODE = 3'd1;
    localparam state_t ST_EXEC   = 3'd2;
    localparam state_t ST_MEM    = 3'd3;
    localparam state_t ST_WB     = 3'd4;

endpackage

// File: rtl/itype_decode.sv
// Combinational opcode classifier feeding the sequencing FSM with the static
// datapath controls for each supported I-type instruction.
module itype_decode
    import itype_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    output logic       supported_o,
    output logic       ext_zero_o,
    output logic       alu_src_imm_o,
    output logic [2:0] alu_op_o,
    output logic       is_load_o,
    output logic       is_store_o,
    output logic       is_branch_o
);

    always_comb begin
        supported_o   = 1'b1;
        ext_zero_o    = 1'b0;
        alu_src_imm_o = 1'b1;
        alu_op_o      = ALU_ADD;
        is_load_o     = 1'b0;
        is_store_o    = 1'b0;
        is_branch_o   = 1'b0;
        case (opcode_i)
            OP_ADDI: alu_op_o = ALU_ADD;
            OP_SLTI: alu_op_o = ALU_SLT;
            OP_ANDI: begin
                alu_op_o   = ALU_AND;
                ext_zero_o = 1'b1;
            end
            OP_ORI: begin
                alu_op_o   = ALU_OR;
                ext_zero_o = 1'b1;
            end
            // beq compares two registers, so operand B stays on rt
            OP_BEQ: begin
                alu_op_o      = ALU_SUB;
                alu_src_imm_o = 1'b0;
                is_branch_o   = 1'b1;
            end
            OP_LW: is_load_o  = 1'b1;
            OP_SW: is_store_o = 1'b1;
            default: begin
                supported_o   = 1'b0;
                alu_src_imm_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/itype_seq_ctrl.sv
// Multi-cycle IDLE/DECODE/EXEC/MEM/WB controller for the I-type immediate
// datapath, with a memory wait-state timeout and a retired-instruction counter.
module itype_seq_ctrl
    import itype_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [5:0]       opcode,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             ext_zero,
    output logic             alu_src_imm,
    output logic [2:0]       alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             pc_write,
    output logic             pc_branch,
    output logic             illegal,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired
);

    localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] ret_q, ret_d;

    logic       dec_supported, dec_ext_zero, dec_alu_src_imm;
    logic [2:0] dec_alu_op;
    logic       dec_is_load, dec_is_store, dec_is_branch;

    itype_decode u_decode (
        .opcode_i      (op_q),
        .supported_o   (dec_supported),
        .ext_zero_o    (dec_ext_zero),
        .alu_src_imm_o (dec_alu_src_imm),
        .alu_op_o      (dec_alu_op),
        .is_load_o     (dec_is_load),
        .is_store_o    (dec_is_store),
        .is_branch_o   (dec_is_branch)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        ret_d       = ret_q;
        instr_ready = 1'b0;
        ext_zero    = 1'b0;
        alu_src_imm = 1'b0;
        alu_op      = ALU_ADD;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        pc_write    = 1'b0;
        pc_branch   = 1'b0;
        illegal     = 1'b0;
        mem_err     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    op_d    = opcode;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_supported) begin
                    state_d = ST_EXEC;
                end else begin
                    illegal = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                ext_zero    = dec_ext_zero;
                alu_src_imm = dec_alu_src_imm;
                alu_op      = dec_alu_op;
                if (dec_is_branch) begin
                    pc_write  = 1'b1;
                    pc_branch = alu_zero;
                    ret_d     = ret_q + 1'b1;
                    state_d   = ST_IDLE;
                end else if (dec_is_load || dec_is_store) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            // mem_ready wins over the timeout when both land on the same cycle
            ST_MEM: begin
                ext_zero    = dec_ext_zero;
                alu_src_imm = dec_alu_src_imm;
                alu_op      = dec_alu_op;
                mem_read    = dec_is_load;
                mem_write   = dec_is_store;
                if (mem_ready) begin
                    cnt_d = '0;
                    if (dec_is_load) begin
                        state_d = ST_WB;
                    end else begin
                        pc_write = 1'b1;
                        ret_d    = ret_q + 1'b1;
                        state_d  = ST_IDLE;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    mem_err = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                mem_to_reg = dec_is_load;
                ret_d      = ret_q + 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            ret_q   <= ret_d;
        end
    end

    assign retired = ret_q;

endmodule

// File: tb/tb_itype_seq_ctrl.sv
// Directed bench for itype_seq_ctrl: a per-cycle vector table covering every
// opcode class, plus hand-written timeout and mid-MEM reset sequences.
module tb_itype_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [5:0]  opcode;
    logic        alu_zero;
    logic        mem_ready;
    logic        ext_zero;
    logic        alu_src_imm;
    logic [2:0]  alu_op;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        pc_write;
    logic        pc_branch;
    logic        illegal;
    logic        mem_err;
    logic [15:0] retired;

    always #5 clk = ~clk;

    itype_seq_ctrl #(.MEM_TIMEOUT(8), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .alu_zero    (alu_zero),
        .mem_ready   (mem_ready),
        .ext_zero    (ext_zero),
        .alu_src_imm (alu_src_imm),
        .alu_op      (alu_op),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .pc_write    (pc_write),
        .pc_branch   (pc_branch),
        .illegal     (illegal),
        .mem_err     (mem_err),
        .retired     (retired)
    );

    // Control bus layout: {ready, ext_zero, alu_src_imm, alu_op[2:0], mem_read,
    // mem_write, reg_write, mem_to_reg, pc_write, pc_branch, illegal, mem_err}
    localparam logic [13:0] RDY = 14'h2000;
    localparam logic [13:0] EZ  = 14'h1000;
    localparam logic [13:0] SRC = 14'h0800;
    localparam logic [13:0] A_ADD = 14'h0000;
    localparam logic [13:0] A_SUB = 14'h0100;
    localparam logic [13:0] A_AND = 14'h0200;
    localparam logic [13:0] A_OR  = 14'h0300;
    localparam logic [13:0] A_SLT = 14'h0400;
    localparam logic [13:0] MRD = 14'h0080;
    localparam logic [13:0] MWR = 14'h0040;
    localparam logic [13:0] RW  = 14'h0020;
    localparam logic [13:0] M2R = 14'h0010;
    localparam logic [13:0] PCW = 14'h0008;
    localparam logic [13:0] PCB = 14'h0004;
    localparam logic [13:0] ILL = 14'h0002;
    localparam logic [13:0] ERR = 14'h0001;
    localparam logic [13:0] NONE = 14'h0000;

    logic [13:0] ctlBus;
    assign ctlBus = {instr_ready, ext_zero, alu_src_imm, alu_op, mem_read, mem_write,
                     reg_write, mem_to_reg, pc_write, pc_branch, illegal, mem_err};

    typedef struct {
        logic        valid;
        logic [5:0]  op;
        logic        az;
        logic        mr;
        logic [13:0] ctl;
        logic [15:0] ret;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic addVec(input logic v, input logic [5:0] op, input logic az,
                          input logic mr, input logic [13:0] ctl, input logic [15:0] ret);
        vec_t e;
        e.valid = v;
        e.op    = op;
        e.az    = az;
        e.mr    = mr;
        e.ctl   = ctl;
        e.ret   = ret;
        vecs.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [5:0] op, input logic az, input logic mr);
        instr_valid = v;
        opcode      = op;
        alu_zero    = az;
        mem_ready   = mr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // andi
        addVec(1, 6'h0C, 0, 0, RDY, 0);
        addVec(0, 6'h00, 0, 0, NONE, 0);
        addVec(0, 6'h00, 0, 0, EZ | SRC | A_AND, 0);
        addVec(0, 6'h00, 0, 0, RW | PCW, 0);
        // addi
        addVec(1, 6'h08, 0, 0, RDY, 1);
        addVec(0, 6'h00, 0, 0, NONE, 1);
        addVec(0, 6'h00, 0, 0, SRC | A_ADD, 1);
        addVec(0, 6'h00, 0, 0, RW | PCW, 1);
        // beq taken; alu_zero only matters in EXEC
        addVec(1, 6'h04, 0, 0, RDY, 2);
        addVec(0, 6'h00, 1, 0, NONE, 2);
        addVec(0, 6'h00, 1, 0, A_SUB | PCW | PCB, 2);
        // lw with three wait states
        addVec(1, 6'h23, 0, 0, RDY, 3);
        addVec(0, 6'h00, 0, 0, NONE, 3);
        addVec(0, 6'h00, 0, 0, SRC | A_ADD, 3);
        addVec(0, 6'h00, 0, 0, SRC | MRD, 3);
        addVec(0, 6'h00, 0, 0, SRC | MRD, 3);
        addVec(0, 6'h00, 0, 0, SRC | MRD, 3);
        addVec(0, 6'h00, 0, 1, SRC | MRD, 3);
        addVec(0, 6'h00, 0, 0, RW | M2R | PCW, 3);
        // sw with immediate mem_ready; mem_ready outside MEM is ignored
        addVec(1, 6'h2B, 0, 0, RDY, 4);
        addVec(0, 6'h00, 0, 1, NONE, 4);
        addVec(0, 6'h00, 0, 1, SRC | A_ADD, 4);
        addVec(0, 6'h00, 0, 1, SRC | MWR | PCW, 4);
        // illegal opcode
        addVec(1, 6'h3F, 0, 0, RDY, 5);
        addVec(0, 6'h00, 0, 0, ILL, 5);
        addVec(0, 6'h00, 0, 0, RDY, 5);
        // slti
        addVec(1, 6'h0A, 0, 0, RDY, 5);
        addVec(0, 6'h00, 0, 0, NONE, 5);
        addVec(0, 6'h00, 0, 0, SRC | A_SLT, 5);
        addVec(0, 6'h00, 0, 0, RW | PCW, 5);
        // ori
        addVec(1, 6'h0D, 0, 0, RDY, 6);
        addVec(0, 6'h00, 0, 0, NONE, 6);
        addVec(0, 6'h00, 0, 0, EZ | SRC | A_OR, 6);
        addVec(0, 6'h00, 0, 0, RW | PCW, 6);
        // beq not taken
        addVec(1, 6'h04, 1, 0, RDY, 7);
        addVec(0, 6'h00, 1, 0, NONE, 7);
        addVec(0, 6'h00, 0, 0, A_SUB | PCW, 7);
        addVec(0, 6'h00, 0, 0, RDY, 8);

        reset = 1'b1;
        applyStimulus(0, 6'h00, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("reset ctl", {2'b00, ctlBus}, {2'b00, RDY});
        checkOutput("reset retired", retired, 16'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].valid, vecs[i].op, vecs[i].az, vecs[i].mr);
            checkOutput($sformatf("vec%0d ctl", i), {2'b00, ctlBus}, {2'b00, vecs[i].ctl});
            checkOutput($sformatf("vec%0d retired", i), retired, vecs[i].ret);
            tick();
        end

        // sw timeout: eight MEM cycles, error pulse on the last one
        applyStimulus(1, 6'h2B, 0, 0);
        tick();
        applyStimulus(0, 6'h00, 0, 0);
        tick();
        tick();
        for (int k = 1; k <= 8; k++) begin
            checkOutput($sformatf("sw tmo mem%0d", k), {2'b00, ctlBus},
                        {2'b00, SRC | MWR | ((k == 8) ? ERR : NONE)});
            tick();
        end
        checkOutput("sw tmo idle ctl", {2'b00, ctlBus}, {2'b00, RDY});
        checkOutput("sw tmo retired", retired, 16'd8);

        // lw whose mem_ready arrives on the timeout cycle itself succeeds
        applyStimulus(1, 6'h23, 0, 0);
        tick();
        applyStimulus(0, 6'h00, 0, 0);
        tick();
        tick();
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(0, 6'h00, 0, (k == 8));
            checkOutput($sformatf("lw edge mem%0d", k), {2'b00, ctlBus}, {2'b00, SRC | MRD});
            tick();
        end
        applyStimulus(0, 6'h00, 0, 0);
        checkOutput("lw edge wb", {2'b00, ctlBus}, {2'b00, RW | M2R | PCW});
        tick();
        checkOutput("lw edge retired", retired, 16'd9);

        // reset while lw is waiting in MEM
        applyStimulus(1, 6'h23, 0, 0);
        tick();
        applyStimulus(0, 6'h00, 0, 0);
        tick();
        tick();
        checkOutput("rst mem before", {2'b00, ctlBus}, {2'b00, SRC | MRD});
        reset = 1'b1;
        tick();
        checkOutput("rst mem ctl", {2'b00, ctlBus}, {2'b00, RDY});
        checkOutput("rst mem retired", retired, 16'd0);
        reset = 1'b0;

        // controller is fully usable after the mid-MEM reset
        applyStimulus(1, 6'h08, 0, 0);
        tick();
        applyStimulus(0, 6'h00, 0, 0);
        tick();
        tick();
        checkOutput("post rst wb", {2'b00, ctlBus}, {2'b00, RW | PCW});
        tick();
        checkOutput("post rst retired", retired, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
